stopwatch_ctrl: RTL

Sequencing controller for a chain of cascaded modulo-10 (BCD) digit counters, forming a start/stop/lap stopwatch. It divides the system clock into count ticks, generates per-digit enable pulses with correct decimal carry, tracks run/pause/overflow state, and captures lap snapshots. It sits between front-panel pulse inputs (already debounced and one-cycle wide) and the display driver.

---
 rtl/stopwatch_pkg.sv | 20 ++
 rtl/bcd_digit.sv | 25 ++
 rtl/stopwatch_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller and its BCD digit cells.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    HALT  = 2'd3
  } sw_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Prescaler width: enough bits for 0..TICK_DIV-1, never narrower than one bit.
  function automatic int unsigned presc_width(input int unsigned tick_div);
    int unsigned w;
    w = $clog2(tick_div);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One modulo-10 counter cell: synchronous clear, increment on en, wraps 9 to 0.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] q,
  output logic       at_max
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (en) begin
      q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
    end
  end

  assign at_max = (q == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop/lap stopwatch: tick prescaler, BCD carry chain, run/pause/halt FSM
// and lap capture over a chain of bcd_digit cells.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic [4*DIGITS-1:0]   lap_bcd,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  running,
  output logic                  overflow
);

  localparam int unsigned PW = presc_width(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  sw_state_t         state;
  logic [PW-1:0]     presc;
  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] en_c;
  logic              tick_c;
  logic              all_max_c;
  logic              do_start_c;
  logic              do_lap_c;

  // Only the highest-priority pulse present in a cycle acts (clear > stop > start > lap).
  assign do_start_c = start && !stop && !clear;
  assign do_lap_c   = lap && !start && !stop && !clear;

  // A stop or clear in the tick cycle swallows the tick.
  assign tick_c    = (state == RUN) && (presc == PRESC_LAST) && !stop && !clear;
  assign all_max_c = &at_max;

  // Decimal carry chain; gated off on overflow so the count holds at all 9s.
  always_comb begin
    logic carry;
    en_c  = '0;
    carry = tick_c && !all_max_c;
    for (int k = 0; k < int'(DIGITS); k++) begin
      en_c[k] = carry;
      carry   = carry && at_max[k];
    end
  end

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
    bcd_digit u_digit (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clear),
      .en      (en_c[g]),
      .q       (count_bcd[4*g +: 4]),
      .at_max  (at_max[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      presc    <= '0;
      running  <= 1'b0;
      overflow <= 1'b0;
      lap_bcd  <= '0;
      digit_en <= '0;
    end else begin
      digit_en <= en_c;
      if (clear) begin
        state    <= IDLE;
        presc    <= '0;
        running  <= 1'b0;
        overflow <= 1'b0;
        lap_bcd  <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (do_start_c) begin
              state   <= RUN;
              presc   <= '0;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (stop) begin
              state   <= PAUSE;
              running <= 1'b0;
            end else begin
              if (do_lap_c) lap_bcd <= count_bcd;
              if (tick_c) begin
                presc <= '0;
                if (all_max_c) begin
                  state    <= HALT;
                  running  <= 1'b0;
                  overflow <= 1'b1;
                end
              end else begin
                presc <= presc + PW'(1);
              end
            end
          end
          PAUSE: begin
            if (do_start_c) begin
              state   <= RUN;
              running <= 1'b1;
            end else if (do_lap_c) begin
              lap_bcd <= count_bcd;
            end
          end
          HALT: begin
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
